// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkt_tx
//  Description : Packet source for the 1x3 router input port. Accepts a packet
//                command and emits header, payload (incrementing or LFSR) and
//                parity bytes, stalling on router busy, with an optional
//                busy-timeout abort and a post-packet idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_tx #(
    parameter int GAP_CYCLES = 2,     // idle cycles after parity, 1..15
    parameter int TIMEOUT    = 255    // consecutive busy cycles before abort, 0 = off
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       cmd_mode,
    input  logic [7:0] cmd_seed,
    input  logic       cmd_bad_parity,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_active,
    output logic       tx_done,
    output logic       cmd_err,
    output logic       timeout_err
);

    localparam logic [2:0]  c_IDLE     = 3'd0;
    localparam logic [2:0]  c_HEADER   = 3'd1;
    localparam logic [2:0]  c_PAYLOAD  = 3'd2;
    localparam logic [2:0]  c_PARITY   = 3'd3;
    localparam logic [2:0]  c_GAP      = 3'd4;

    localparam logic [3:0]  c_GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic        c_TO_EN    = (TIMEOUT != 0);
    localparam logic [15:0] c_TO_LAST  = 16'(TIMEOUT - 1);

    logic [2:0]  state_q,  state_d;
    logic [1:0]  addr_q,   addr_d;
    logic [5:0]  len_q,    len_d;
    logic        mode_q,   mode_d;
    logic        bad_q,    bad_d;
    logic [7:0]  byte_q,   byte_d;
    logic [5:0]  rem_q,    rem_d;
    logic [7:0]  parity_q, parity_d;
    logic [3:0]  gap_q,    gap_d;
    logic [15:0] to_q,     to_d;
    logic        tx_done_q,     tx_done_d;
    logic        cmd_err_q,     cmd_err_d;
    logic        timeout_err_q, timeout_err_d;

    logic        w_in_pkt;
    logic        w_abort;

    // Payload successor: +1 in incrementing mode, Fibonacci LFSR step otherwise
    function automatic logic [7:0] f_next_byte(input logic [7:0] cur, input logic mode);
        if (mode)
            f_next_byte = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
        else
            f_next_byte = cur + 8'd1;
    endfunction

    // State and datapath registers; reset truncates any packet in flight
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= c_IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            mode_q        <= 1'b0;
            bad_q         <= 1'b0;
            byte_q        <= '0;
            rem_q         <= '0;
            parity_q      <= '0;
            gap_q         <= '0;
            to_q          <= '0;
            tx_done_q     <= 1'b0;
            cmd_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            mode_q        <= mode_d;
            bad_q         <= bad_d;
            byte_q        <= byte_d;
            rem_q         <= rem_d;
            parity_q      <= parity_d;
            gap_q         <= gap_d;
            to_q          <= to_d;
            tx_done_q     <= tx_done_d;
            cmd_err_q     <= cmd_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state: command latch, byte consumption on !busy, gap count, timeout abort
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        mode_d        = mode_q;
        bad_d         = bad_q;
        byte_d        = byte_q;
        rem_d         = rem_q;
        parity_d      = parity_q;
        gap_d         = gap_q;
        tx_done_d     = 1'b0;
        cmd_err_d     = 1'b0;
        timeout_err_d = 1'b0;

        w_in_pkt = (state_q == c_HEADER) || (state_q == c_PAYLOAD) || (state_q == c_PARITY);
        w_abort  = c_TO_EN && w_in_pkt && busy && (to_q == c_TO_LAST);
        // Busy-run length only matters while a byte is waiting to be consumed
        to_d     = (w_in_pkt && busy) ? to_q + 16'd1 : 16'd0;

        case (state_q)
            c_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_addr == 2'd3) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        addr_d   = cmd_addr;
                        len_d    = cmd_len;
                        mode_d   = cmd_mode;
                        bad_d    = cmd_bad_parity;
                        // An all-zero LFSR would lock up, so seed 0 starts at 1
                        byte_d   = (cmd_mode && (cmd_seed == 8'd0)) ? 8'd1 : cmd_seed;
                        rem_d    = cmd_len;
                        parity_d = {cmd_len, cmd_addr};
                        state_d  = c_HEADER;
                    end
                end
            end
            c_HEADER: begin
                if (!busy)
                    state_d = (len_q != 6'd0) ? c_PAYLOAD : c_PARITY;
            end
            c_PAYLOAD: begin
                if (!busy) begin
                    parity_d = parity_q ^ byte_q;
                    byte_d   = f_next_byte(byte_q, mode_q);
                    rem_d    = rem_q - 6'd1;
                    if (rem_q == 6'd1)
                        state_d = c_PARITY;
                end
            end
            c_PARITY: begin
                if (!busy) begin
                    tx_done_d = 1'b1;
                    gap_d     = 4'd0;
                    state_d   = c_GAP;
                end
            end
            c_GAP: begin
                if (gap_q == c_GAP_LAST) begin
                    gap_d   = 4'd0;
                    state_d = c_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = c_IDLE;
        endcase

        if (w_abort) begin
            timeout_err_d = 1'b1;
            gap_d         = 4'd0;
            to_d          = 16'd0;
            state_d       = c_GAP;
        end
    end

    // Outputs decoded from the current state and the latched command
    always_comb begin
        cmd_ready   = (state_q == c_IDLE);
        tx_active   = (state_q != c_IDLE);
        tx_done     = tx_done_q;
        cmd_err     = cmd_err_q;
        timeout_err = timeout_err_q;
        data_out    = 8'd0;
        pkt_valid   = 1'b0;
        case (state_q)
            c_HEADER: begin
                data_out  = {len_q, addr_q};
                pkt_valid = 1'b1;
            end
            c_PAYLOAD: begin
                data_out  = byte_q;
                pkt_valid = 1'b1;
            end
            c_PARITY: begin
                data_out  = parity_q ^ {7'b0, bad_q};
                pkt_valid = 1'b0;
            end
            default: begin
                data_out  = 8'd0;
                pkt_valid = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_router_pkt_tx
//  Description : Self-checking bench for router_pkt_tx. Command table plus
//                scoreboard of expected consumed bytes, and directed sequences
//                for stall, illegal address, timeout and mid-packet reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_tx;

    localparam int GAP = 2;
    localparam int TO  = 4;

    logic       clock = 1'b0;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       cmd_mode;
    logic [7:0] cmd_seed;
    logic       cmd_bad_parity;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_active;
    logic       tx_done;
    logic       cmd_err;
    logic       timeout_err;

    router_pkt_tx #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_mode       (cmd_mode),
        .cmd_seed       (cmd_seed),
        .cmd_bad_parity (cmd_bad_parity),
        .busy           (busy),
        .data_out       (data_out),
        .pkt_valid      (pkt_valid),
        .tx_active      (tx_active),
        .tx_done        (tx_done),
        .cmd_err        (cmd_err),
        .timeout_err    (timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] addr;
        logic [5:0] len;
        logic       mode;
        logic [7:0] seed;
        logic       bad;
        logic [7:0] exp_hdr;
        logic [7:0] exp_par;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       valid;
    } exp_t;

    vec_t vecs [5];
    exp_t sbq [$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en       = 1'b1;
    bit in_pkt       = 1'b0;
    bit done_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] model_next(input logic [7:0] cur, input logic mode);
        if (mode) return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
        return cur + 8'd1;
    endfunction

    // Expected consumed bytes for one command: header, payload run, parity
    task automatic push_pkt(input vec_t v);
        logic [7:0] b;
        sbq.push_back('{v.exp_hdr, 1'b1});
        b = (v.mode && v.seed == 8'd0) ? 8'd1 : v.seed;
        for (int i = 0; i < int'(v.len); i++) begin
            sbq.push_back('{b, 1'b1});
            b = model_next(b, v.mode);
        end
        sbq.push_back('{v.exp_par, 1'b0});
    endtask

    task automatic send_cmd(input logic [1:0] a, input logic [5:0] l, input logic m,
                            input logic [7:0] s, input logic bp);
        cmd_addr       = a;
        cmd_len        = l;
        cmd_mode       = m;
        cmd_seed       = s;
        cmd_bad_parity = bp;
        cmd_valid      = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid      = 1'b0;
    endtask

    // Wait for return to IDLE; optionally measure tx_done-to-ready distance
    task automatic wait_idle(input bit check_gap);
        int  d  = -1;
        bit  ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (tx_done) d = i;
            if (cmd_ready) begin
                ok = 1'b1;
                if (check_gap) chk("gap_len", 32'(i - d), 32'(GAP));
                break;
            end
        end
        if (!ok) chk("idle_timeout", 32'(0), 32'(1));
        chk("sb_drained", 32'(sbq.size()), 32'(0));
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: pops one expected byte per consuming edge
    always @(negedge clock) begin
        if (done_pending) begin
            chk("tx_done", 32'(tx_done), 32'(1));
            done_pending = 1'b0;
        end else if (tx_done) begin
            chk("tx_done_spurious", 32'(tx_done), 32'(0));
        end
        if (mon_en && resetn && !busy && (pkt_valid || (in_pkt && tx_active))) begin
            if (sbq.size() == 0) begin
                chk("sb_extra_byte", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_data", 32'(data_out), 32'(e.data));
                chk("sb_valid", 32'(pkt_valid), 32'(e.valid));
                if (!e.valid) begin
                    in_pkt       = 1'b0;
                    done_pending = 1'b1;
                end else begin
                    in_pkt = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'd1, 6'd3, 1'b0, 8'hFE, 1'b0, 8'h0D, 8'h0C};
        vecs[1] = '{2'd2, 6'd0, 1'b0, 8'h00, 1'b1, 8'h02, 8'h03};
        vecs[2] = '{2'd0, 6'd2, 1'b1, 8'h00, 1'b0, 8'h08, 8'h0B};
        vecs[3] = '{2'd0, 6'd1, 1'b0, 8'h5A, 1'b0, 8'h04, 8'h5E};
        vecs[4] = '{2'd2, 6'd4, 1'b1, 8'h80, 1'b0, 8'h12, 8'h95};

        resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        cmd_mode = 1'b0; cmd_seed = '0; cmd_bad_parity = 1'b0; busy = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_cmd_ready",   32'(cmd_ready),   32'(1));
        chk("rst_pkt_valid",   32'(pkt_valid),   32'(0));
        chk("rst_data_out",    32'(data_out),    32'(0));
        chk("rst_tx_active",   32'(tx_active),   32'(0));
        chk("rst_pulses",      32'({tx_done, cmd_err, timeout_err}), 32'(0));
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // Table-driven packets with busy low
        for (int k = 0; k < 5; k++) begin
            push_pkt(vecs[k]);
            send_cmd(vecs[k].addr, vecs[k].len, vecs[k].mode, vecs[k].seed, vecs[k].bad);
            wait_idle(1'b1);
        end

        // Stall: busy high for 3 cycles while 0xFF is presented
        push_pkt(vecs[0]);
        send_cmd(vecs[0].addr, vecs[0].len, vecs[0].mode, vecs[0].seed, vecs[0].bad);
        repeat (2) begin @(posedge clock); #1; end
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_data",  32'(data_out),  32'hFF);
            chk("stall_valid", 32'(pkt_valid), 32'(1));
        end
        @(posedge clock);
        #1;
        chk("stall_still_ff", 32'(data_out), 32'hFF);
        busy = 1'b0;
        wait_idle(1'b1);

        // Illegal address: rejected, nothing transmitted
        send_cmd(2'd3, 6'd4, 1'b0, 8'h33, 1'b0);
        @(negedge clock);
        chk("err_cmd_err",   32'(cmd_err),   32'(1));
        chk("err_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("err_pkt_valid", 32'(pkt_valid), 32'(0));
        chk("err_tx_active", 32'(tx_active), 32'(0));
        @(negedge clock);
        chk("err_pulse_end", 32'(cmd_err),   32'(0));
        @(posedge clock);
        #1;

        // Timeout: busy stuck high mid-payload
        mon_en = 1'b0;
        send_cmd(2'd0, 6'd5, 1'b0, 8'h10, 1'b0);
        repeat (2) begin @(posedge clock); #1; end
        busy = 1'b1;
        for (int i = 0; i < TO; i++) begin
            @(negedge clock);
            chk("to_hold_valid", 32'(pkt_valid),   32'(1));
            chk("to_no_err_yet", 32'(timeout_err), 32'(0));
        end
        @(negedge clock);
        chk("to_err",        32'(timeout_err), 32'(1));
        chk("to_pkt_valid",  32'(pkt_valid),   32'(0));
        chk("to_data_zero",  32'(data_out),    32'(0));
        chk("to_tx_active",  32'(tx_active),   32'(1));
        @(negedge clock);
        chk("to_err_pulse",  32'(timeout_err), 32'(0));
        wait_idle(1'b0);
        busy   = 1'b0;
        mon_en = 1'b1;

        // Reset in the middle of a payload
        push_pkt(vecs[4]);
        send_cmd(vecs[4].addr, vecs[4].len, vecs[4].mode, vecs[4].seed, vecs[4].bad);
        repeat (2) begin @(posedge clock); #1; end
        mon_en = 1'b0;
        resetn = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_mid_valid",  32'(pkt_valid), 32'(0));
        chk("rst_mid_ready",  32'(cmd_ready), 32'(1));
        chk("rst_mid_active", 32'(tx_active), 32'(0));
        chk("rst_mid_data",   32'(data_out),  32'(0));
        @(posedge clock);
        #1;
        resetn = 1'b1;
        sbq.delete();
        in_pkt = 1'b0;
        mon_en = 1'b1;

        // Recovery after reset
        push_pkt(vecs[2]);
        send_cmd(vecs[2].addr, vecs[2].len, vecs[2].mode, vecs[2].seed, vecs[2].bad);
        wait_idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet transmitter that drives the 1x3 router input port. It is the source side of the protocol the router FSM receives.
- Takes a packet command (address, length, payload mode, seed).
- Emits header, payload and parity bytes on data_out/pkt_valid, stalling whenever the router asserts busy.
- Used as the on-chip traffic source for router bring-up and self-test.

Parameters:
GAP_CYCLES, 2, minimum idle cycles after a parity byte before the next header (covers router parity-check/reset-internal cycles); legal 1..15.
TIMEOUT, 255, max consecutive busy-high cycles tolerated mid-packet before abort; 0 disables.

Ports:
clock  in  1  clock, rising edge.
resetn  in  1  reset, synchronous, active-low.
cmd_valid  in  1  command request.
cmd_ready  out  1  high only in IDLE; command accepted on edge with cmd_valid&&cmd_ready.
cmd_addr  in  2  destination port 0..2; 3 is illegal.
cmd_len  in  6  payload byte count 0..63.
cmd_mode  in  1  0 = incrementing payload, 1 = LFSR payload.
cmd_seed  in  8  first payload byte / LFSR seed.
cmd_bad_parity  in  1  invert bit 0 of the transmitted parity byte.
busy  in  1  router busy; a byte is consumed only at an edge where busy==0.
data_out  out  8  router data_in.
pkt_valid  out  1  high during header and payload bytes, low during parity.
tx_active  out  1  high from command accept until GAP exit or abort.
tx_done  out  1  one-cycle pulse when the parity byte is consumed.
cmd_err  out  1  one-cycle pulse when an addr==3 command is rejected.
timeout_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset, synchronous (resetn low at an edge):
  - state=IDLE; all outputs 0 except cmd_ready=1.
  - Counters, parity accumulator and payload register cleared.
  - Reset mid-packet truncates the packet immediately; pkt_valid drops the next cycle.
- States: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - cmd_ready=1, pkt_valid=0, data_out=0.
  - On accept with cmd_addr!=3: latch the command, go to HEADER next cycle.
  - On accept with cmd_addr==3: pulse cmd_err, stay in IDLE.
- HEADER:
  - data_out={cmd_len,cmd_addr}, pkt_valid=1; parity accumulator = header.
  - On an edge with busy==0: go to PAYLOAD if len>0, else PARITY.
- PAYLOAD:
  - data_out=current payload byte, pkt_valid=1.
  - On an edge with busy==0: XOR the byte into parity, advance the byte, decrement the remaining count.
  - When the last byte is consumed, go to PARITY.
- Payload sequence:
  - Mode 0: seed, seed+1, … modulo 256 (0xFF wraps to 0x00).
  - Mode 1: first byte = seed (seed 0x00 forced to 0x01); next = {cur[6:0], cur[7]^cur[5]^cur[4]^cur[3]}.
- PARITY:
  - data_out=parity^{7'b0,bad_parity}, pkt_valid=0.
  - On an edge with busy==0: pulse tx_done, go to GAP.
- GAP:
  - pkt_valid=0, data_out=0.
  - Count GAP_CYCLES cycles, then go to IDLE. cmd_ready stays 0 throughout GAP.
- Stall: while busy==1, data_out, pkt_valid, state and counters hold exactly.
- Timeout:
  - Counts consecutive busy==1 cycles in HEADER/PAYLOAD/PARITY; reset whenever busy==0.
  - On reaching TIMEOUT (nonzero): pulse timeout_err, drop pkt_valid, go to GAP. No parity is sent and tx_done does not pulse.
- tx_active=1 in HEADER, PAYLOAD, PARITY and GAP.
- Latency: accept edge → header valid next cycle. With busy low throughout, a len=N packet occupies N+2 data cycles.

Test Plan:
- addr=1, len=3, mode 0, seed 0xFE, busy=0 → bytes 0x0D,0xFE,0xFF,0x00 with pkt_valid=1; then 0x0C with pkt_valid=0; tx_done pulses on the 0x0C edge; cmd_ready returns after 2 GAP cycles.
- Same command with busy held high 3 cycles while 0xFF is presented → 0xFF and pkt_valid held stable 3 extra cycles; final sequence and parity unchanged.
- addr=2, len=0, bad_parity=1 → header 0x02 (pkt_valid=1), then parity 0x03 (pkt_valid=0).
- addr=3 command → cmd_err pulse, no pkt_valid, cmd_ready stays 1.
- mode 1, seed 0x00, len=2 → payload 0x01 then 0x02.
- TIMEOUT=4, busy stuck high in PAYLOAD → timeout_err after 4 cycles, pkt_valid=0, no tx_done.
- resetn low mid-payload → next cycle IDLE, pkt_valid=0, cmd_ready=1.
